kmi_rx_fifo: RTL and testbench

KMI_RX_FIFO -- requirements
Module: kmi_rx_fifo

---
 rtl/kmi_rx_fifo.sv | 177 +++++++++++++++++
 tb/tb_kmi_rx_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/kmi_rx_fifo.sv
// Keyboard/mouse serial receiver: synchronised frame decoder feeding an RX FIFO,
// with an APB register window for data, status and control.
module kmi_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 1,
    parameter int TIMEOUT    = 4096
) (
    input  logic        kmirefclk,
    input  logic        nkmirst,
    input  logic        kmiclkin,
    input  logic        kmidatain,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [1:0]  paddr,
    input  logic [7:0]  pwdata,
    output logic [15:0] prdata,
    output logic        pready,
    output logic        kmiintr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_W + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t              state;
    logic                clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic                fall, din;
    logic [BW-1:0]       bitcnt;
    logic [TW-1:0]       tcnt;
    logic [DATA_W-1:0]   shift;
    logic                par_ok;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wptr, rptr;
    logic [CW-1:0]       count;
    logic                rxen, inten, ovf, perr, ferr;
    logic                empty, full, acc, rd, wr, pop, push, do_push;
    logic                stop_ev, timeout_hit, ovf_set, perr_set, ferr_set, clr;
    logic                unused_ok;

    assign unused_ok = &{1'b0, pwdata[7:3]};

    always_ff @(posedge kmirefclk or negedge nkmirst) begin
        if (!nkmirst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= kmiclkin;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= kmidatain;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;
    assign din  = dat_s2;

    assign empty       = (count == '0);
    assign full        = (count == CW'(DEPTH));
    assign acc         = psel & penable;
    assign rd          = acc & ~pwrite;
    assign wr          = acc & pwrite;
    assign pop         = rd && (paddr == 2'd0) && !empty;
    assign stop_ev     = rxen && (state == STOP) && fall;
    assign timeout_hit = rxen && (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT));
    assign push        = stop_ev && din && par_ok;
    assign do_push     = push && (!full || pop);
    assign ovf_set     = push && full && !pop;
    assign perr_set    = stop_ev && din && !par_ok;
    assign ferr_set    = (stop_ev && !din) || timeout_hit;
    assign clr         = wr && (paddr == 2'd1);
    assign pready      = acc;

    always_ff @(posedge kmirefclk or negedge nkmirst) begin
        if (!nkmirst) begin
            state  <= IDLE;
            bitcnt <= '0;
            tcnt   <= '0;
            shift  <= '0;
            par_ok <= 1'b0;
        end else if (!rxen) begin
            state <= IDLE;
            tcnt  <= '0;
        end else if (state == IDLE) begin
            tcnt <= '0;
            if (fall && !din) begin
                state  <= DATA;
                bitcnt <= '0;
                par_ok <= 1'b1;
            end
        end else if (fall) begin
            tcnt <= '0;
            case (state)
                DATA: begin
                    shift  <= {din, shift[DATA_W-1:1]};
                    bitcnt <= bitcnt + 1'b1;
                    if (bitcnt == BW'(DATA_W - 1))
                        state <= (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY: begin
                    par_ok <= ((^{shift, din}) == (PARITY_ODD != 0));
                    state  <= STOP;
                end
                default: state <= IDLE;
            endcase
        end else if (timeout_hit) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge kmirefclk) begin
        if (do_push)
            mem[wptr] <= shift;
    end

    always_ff @(posedge kmirefclk or negedge nkmirst) begin
        if (!nkmirst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Set events take priority over a same-cycle write-1-to-clear.
    always_ff @(posedge kmirefclk or negedge nkmirst) begin
        if (!nkmirst) begin
            ovf     <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            rxen    <= 1'b0;
            inten   <= 1'b0;
            kmiintr <= 1'b0;
        end else begin
            ovf  <= ovf_set  | (ovf  & ~(clr & pwdata[2]));
            perr <= perr_set | (perr & ~(clr & pwdata[1]));
            ferr <= ferr_set | (ferr & ~(clr & pwdata[0]));
            if (wr && (paddr == 2'd2)) begin
                rxen  <= pwdata[0];
                inten <= pwdata[1];
            end
            kmiintr <= inten & (!empty | ovf | perr | ferr);
        end
    end

    always_comb begin
        prdata = '0;
        if (nkmirst && rd) begin
            case (paddr)
                2'd0:    prdata = empty ? 16'h0000 : 16'(mem[rptr]);
                2'd1:    prdata = {ovf, perr, ferr, full, empty, 4'b0000, 7'(count)};
                2'd2:    prdata = {14'd0, inten, rxen};
                default: prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_kmi_rx_fifo.sv
// Directed bench for kmi_rx_fifo: serial frames in, APB reads checked against a
// queue of expected words.
module tb_kmi_rx_fifo;

    logic        kmirefclk = 1'b0;
    logic        nkmirst   = 1'b0;
    logic        kmiclkin  = 1'b1;
    logic        kmidatain = 1'b1;
    logic        psel      = 1'b0;
    logic        penable   = 1'b0;
    logic        pwrite    = 1'b0;
    logic [1:0]  paddr     = 2'd0;
    logic [7:0]  pwdata    = 8'd0;
    logic [15:0] prdata;
    logic        pready;
    logic        kmiintr;

    int n_asrt = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    kmi_rx_fifo #(.TIMEOUT(64)) dut (
        .kmirefclk (kmirefclk),
        .nkmirst   (nkmirst),
        .kmiclkin  (kmiclkin),
        .kmidatain (kmidatain),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .kmiintr   (kmiintr)
    );

    always #5 kmirefclk = ~kmirefclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb_read(input logic [1:0] a, output logic [15:0] d);
        @(negedge kmirefclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge kmirefclk);
        penable = 1'b1;
        #1;
        d = prdata;
        check("pready", {15'd0, pready}, 16'd1);
        @(negedge kmirefclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_write(input logic [1:0] a, input logic [7:0] v);
        @(negedge kmirefclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = v;
        @(negedge kmirefclk);
        penable = 1'b1;
        @(negedge kmirefclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] d;
        apb_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic read_fifo(input string tag);
        logic [15:0] d;
        logic [15:0] exp;
        apb_read(2'd0, d);
        exp = (exp_q.size() > 0) ? {8'd0, exp_q.pop_front()} : 16'h0000;
        check(tag, d, exp);
    endtask

    task automatic send_bit(input logic b);
        @(negedge kmirefclk);
        kmidatain = b;
        repeat (2) @(negedge kmirefclk);
        kmiclkin = 1'b0;
        repeat (8) @(negedge kmirefclk);
        kmiclkin = 1'b1;
        repeat (8) @(negedge kmirefclk);
    endtask

    task automatic send_head(input logic [7:0] w, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
        send_bit(par);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic par, input logic stp);
        send_head(w, par);
        send_bit(stp);
    endtask

    function automatic logic odd_par(input logic [7:0] w);
        return ~(^w);
    endfunction

    task automatic send_good(input logic [7:0] w);
        send_frame(w, odd_par(w), 1'b1);
        if (exp_q.size() < 4) exp_q.push_back(w);
    endtask

    initial begin
        logic [15:0] d;

        // Reset state, including an APB read while reset is held
        repeat (3) @(negedge kmirefclk);
        check("rst_intr", {15'd0, kmiintr}, 16'd0);
        check_reg("rst_status_in_reset", 2'd1, 16'h0000);
        nkmirst = 1'b1;
        check_reg("rst_status", 2'd1, 16'h0800);
        check_reg("rst_ctrl", 2'd2, 16'h0000);
        check_reg("rst_addr0", 2'd0, 16'h0000);

        apb_write(2'd2, 8'hFF);
        check_reg("ctrl_rw", 2'd2, 16'h0003);
        check_reg("addr3", 2'd3, 16'h0000);

        // Basic frame 0xCD, odd parity bit 0
        send_frame(8'hCD, 1'b0, 1'b1);
        exp_q.push_back(8'hCD);
        check_reg("cd_status", 2'd1, 16'h0001);
        check("cd_intr_hi", {15'd0, kmiintr}, 16'd1);
        read_fifo("cd_data");
        check_reg("cd_empty", 2'd1, 16'h0800);
        repeat (2) @(negedge kmirefclk);
        check("cd_intr_lo", {15'd0, kmiintr}, 16'd0);

        // Parity error, then W1C
        send_frame(8'hCD, 1'b1, 1'b1);
        check_reg("perr_status", 2'd1, 16'h4800);
        check("perr_intr", {15'd0, kmiintr}, 16'd1);
        apb_write(2'd1, 8'h02);
        check_reg("perr_clr", 2'd1, 16'h0800);

        // Overflow with DEPTH+1 frames
        for (int i = 1; i <= 5; i++) send_good(8'(i));
        check_reg("ovf_status", 2'd1, 16'h9004);
        for (int i = 0; i < 5; i++) read_fifo("ovf_data");
        apb_write(2'd1, 8'h04);
        check_reg("ovf_clr", 2'd1, 16'h0800);

        // Stop bit 0 -> frame error
        send_frame(8'h3C, odd_par(8'h3C), 1'b0);
        check_reg("stop0_status", 2'd1, 16'h2800);
        apb_write(2'd1, 8'h01);
        check_reg("stop0_clr", 2'd1, 16'h0800);

        // Frame halted after 3 data bits -> timeout frame error
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        repeat (200) @(negedge kmirefclk);
        check_reg("tmo_status", 2'd1, 16'h2800);
        apb_write(2'd1, 8'h01);
        send_good(8'h5A);
        check_reg("tmo_next_status", 2'd1, 16'h0001);
        read_fifo("tmo_next_data");

        // Full FIFO: pop lands on the same edge as the fifth push
        for (int i = 0; i < 4; i++) send_good(8'(8'h10 + i));
        check_reg("sim_full", 2'd1, 16'h1004);
        send_head(8'h14, odd_par(8'h14));
        @(negedge kmirefclk);
        kmidatain = 1'b1;
        repeat (2) @(negedge kmirefclk);
        kmiclkin = 1'b0;
        apb_read(2'd0, d);
        check("sim_pop", d, {8'd0, exp_q.pop_front()});
        exp_q.push_back(8'h14);
        repeat (6) @(negedge kmirefclk);
        kmiclkin = 1'b1;
        repeat (8) @(negedge kmirefclk);
        check_reg("sim_status", 2'd1, 16'h1004);
        for (int i = 0; i < 5; i++) read_fifo("sim_data");

        // Reset mid-frame
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        @(negedge kmirefclk);
        nkmirst = 1'b0;
        exp_q.delete();
        @(negedge kmirefclk);
        check("mid_rst_intr", {15'd0, kmiintr}, 16'd0);
        check_reg("mid_rst_status_in", 2'd1, 16'h0000);
        nkmirst = 1'b1;
        check_reg("mid_rst_status", 2'd1, 16'h0800);
        check_reg("mid_rst_ctrl", 2'd2, 16'h0000);
        apb_write(2'd2, 8'h03);
        send_good(8'hA5);
        read_fifo("mid_rst_a5");
        check_reg("final_status", 2'd1, 16'h0800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
